// File: rtl/id_stage.sv
// Decode stage of a 4-bit-opcode pipeline: IF/ID latch, 64x32 register file
// with write-back forwarding, and the ID/EX latch driving all ex_* outputs.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [5:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [5:0]  ex_rd,
  output logic [5:0]  ex_rs1,
  output logic [5:0]  ex_rs2,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_pc,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_jump,
  output logic        ex_brz,
  output logic        ex_brn
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ST   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_INC  = 4'b0101,
    OP_NEG  = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_J    = 4'b1000,
    OP_BRZ  = 4'b1001,
    OP_JM   = 4'b1010,
    OP_BRN  = 4'b1011,
    OP_LD   = 4'b1110,
    OP_SVPC = 4'b1111
  } opcode_t;

  // Only [31:10] carries meaning; the low bits are dropped at the latch.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_in[9:0];

  logic [31:10] if_inst;
  logic [31:0]  if_pc;
  logic         if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_inst  <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_inst  <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_inst  <= inst_in[31:10];
      if_pc    <= pc_in;
      if_valid <= 1'b1;
    end
  end

  logic [3:0] id_op;
  logic [5:0] id_rd;
  logic [5:0] id_rs1;
  logic [5:0] id_rs2;

  assign id_op  = if_inst[31:28];
  assign id_rd  = if_inst[27:22];
  assign id_rs1 = if_inst[21:16];
  assign id_rs2 = if_inst[15:10];

  logic [31:0] regs [64];

  // Write-back happens regardless of stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [31:0] rd_a;
  logic [31:0] rd_b;

  assign rd_a = (wb_en && (wb_addr == id_rs1)) ? wb_data : regs[id_rs1];
  assign rd_b = (wb_en && (wb_addr == id_rs2)) ? wb_data : regs[id_rs2];

  logic dec_legal;
  logic dec_regwrite;
  logic dec_memread;
  logic dec_memwrite;
  logic dec_jump;
  logic dec_brz;
  logic dec_brn;

  always_comb begin
    dec_legal    = 1'b1;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_jump     = 1'b0;
    dec_brz      = 1'b0;
    dec_brn      = 1'b0;
    case (id_op)
      OP_SVPC, OP_ADD, OP_INC, OP_NEG, OP_SUB: dec_regwrite = 1'b1;
      OP_LD: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      OP_ST:  dec_memwrite = 1'b1;
      OP_J:   dec_jump     = 1'b1;
      OP_JM: begin
        dec_jump    = 1'b1;
        dec_memread = 1'b1;
      end
      OP_BRZ: dec_brz = 1'b1;
      OP_BRN: dec_brn = 1'b1;
      default: dec_legal = 1'b0;  // NOP and unassigned opcodes become bubbles
    endcase
  end

  logic issue;
  assign issue = if_valid && dec_legal && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_pc       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_jump     <= 1'b0;
      ex_brz      <= 1'b0;
      ex_brn      <= 1'b0;
    end else if (issue) begin
      ex_valid    <= 1'b1;
      ex_op       <= id_op;
      ex_rd       <= id_rd;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_a        <= rd_a;
      ex_b        <= rd_b;
      ex_pc       <= if_pc;
      ex_regwrite <= dec_regwrite;
      ex_memread  <= dec_memread;
      ex_memwrite <= dec_memwrite;
      ex_jump     <= dec_jump;
      ex_brz      <= dec_brz;
      ex_brn      <= dec_brn;
    end else begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_pc       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_jump     <= 1'b0;
      ex_brz      <= 1'b0;
      ex_brn      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: write-back, forwarding, stall, flush,
// bubble opcodes, branch/jump controls and mid-stream reset.
module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [5:0]  ex_rd;
  logic [5:0]  ex_rs1;
  logic [5:0]  ex_rs2;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_pc;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_jump;
  logic        ex_brz;
  logic        ex_brn;

  int n_checks = 0;
  int n_pass   = 0;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .pc_in(pc_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc(ex_pc), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_jump(ex_jump), .ex_brz(ex_brz),
    .ex_brn(ex_brn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                     input logic [5:0] rs1, input logic [5:0] rs2);
    return {op, rd, rs1, rs2, 10'h000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    inst_in = '0;
    pc_in   = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    tick();
    check("reset_valid", {31'b0, ex_valid}, 32'd0);
    check("reset_a", ex_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Register writes, then SUB rd=5 rs1=6 rs2=6
    wb_en = 1'b1; wb_addr = 6'd5; wb_data = 32'h0000_0007;
    tick();
    wb_addr = 6'd6; wb_data = 32'h0000_0003;
    tick();
    wb_en = 1'b0;
    inst_in = 32'h7146_1800; pc_in = 32'h0000_0100;
    tick();
    inst_in = '0; pc_in = 32'h0000_0104;
    tick();
    check("sub_valid", {31'b0, ex_valid}, 32'd1);
    check("sub_op", {28'b0, ex_op}, 32'h7);
    check("sub_rd", {26'b0, ex_rd}, 32'd5);
    check("sub_a", ex_a, 32'h3);
    check("sub_b", ex_b, 32'h3);
    check("sub_pc", ex_pc, 32'h0000_0100);
    check("sub_regwrite", {31'b0, ex_regwrite}, 32'd1);

    // ADD rs1=6 with same-cycle write-back to R6
    inst_in = mk(4'h4, 6'd1, 6'd6, 6'd5);
    tick();
    inst_in = '0;
    wb_en = 1'b1; wb_addr = 6'd6; wb_data = 32'h0000_00AA;
    tick();
    wb_en = 1'b0;
    check("fwd_a", ex_a, 32'h0000_00AA);
    check("fwd_b", ex_b, 32'h0000_0007);
    check("fwd_rs1", {26'b0, ex_rs1}, 32'd6);

    // LD held by 2 stall cycles
    inst_in = mk(4'hE, 6'd2, 6'd5, 6'd0); pc_in = 32'h0000_0200;
    tick();
    inst_in = '0; stall = 1'b1;
    tick();
    check("stall_bubble1", {31'b0, ex_valid}, 32'd0);
    tick();
    check("stall_bubble2", {31'b0, ex_valid}, 32'd0);
    check("stall_bubble2_memread", {31'b0, ex_memread}, 32'd0);
    stall = 1'b0;
    tick();
    check("ld_valid", {31'b0, ex_valid}, 32'd1);
    check("ld_memread", {31'b0, ex_memread}, 32'd1);
    check("ld_op", {28'b0, ex_op}, 32'hE);
    check("ld_a", ex_a, 32'h7);
    check("ld_pc", ex_pc, 32'h0000_0200);
    tick();
    check("ld_once", {31'b0, ex_valid}, 32'd0);

    // Flush and stall together discard held ST
    inst_in = mk(4'h3, 6'd0, 6'd5, 6'd6);
    tick();
    inst_in = '0; flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_cyc1", {31'b0, ex_valid}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("flush_cyc2", {31'b0, ex_valid}, 32'd0);
    check("flush_memwrite", {31'b0, ex_memwrite}, 32'd0);

    // Bubble opcodes and branch/jump controls
    inst_in = mk(4'hC, 6'd3, 6'd5, 6'd6);
    tick();
    inst_in = mk(4'h0, 6'd3, 6'd5, 6'd6);
    tick();
    check("op1100_valid", {31'b0, ex_valid}, 32'd0);
    check("op1100_regwrite", {31'b0, ex_regwrite}, 32'd0);
    inst_in = mk(4'hB, 6'd0, 6'd5, 6'd0);
    tick();
    check("nop_valid", {31'b0, ex_valid}, 32'd0);
    inst_in = mk(4'h8, 6'd0, 6'd0, 6'd0);
    tick();
    check("brn_valid", {31'b0, ex_valid}, 32'd1);
    check("brn_brn", {31'b0, ex_brn}, 32'd1);
    check("brn_regwrite", {31'b0, ex_regwrite}, 32'd0);
    check("brn_brz", {31'b0, ex_brz}, 32'd0);
    inst_in = mk(4'hA, 6'd0, 6'd6, 6'd0);
    tick();
    check("j_jump", {31'b0, ex_jump}, 32'd1);
    check("j_memread", {31'b0, ex_memread}, 32'd0);
    inst_in = mk(4'hF, 6'd9, 6'd0, 6'd0);
    tick();
    check("jm_jump", {31'b0, ex_jump}, 32'd1);
    check("jm_memread", {31'b0, ex_memread}, 32'd1);
    inst_in = mk(4'h9, 6'd0, 6'd5, 6'd0);
    tick();
    check("svpc_regwrite", {31'b0, ex_regwrite}, 32'd1);
    check("svpc_rd", {26'b0, ex_rd}, 32'd9);
    inst_in = '0;
    tick();
    check("brz_brz", {31'b0, ex_brz}, 32'd1);
    check("brz_regwrite", {31'b0, ex_regwrite}, 32'd0);

    // Mid-stream reset
    inst_in = mk(4'h4, 6'd1, 6'd6, 6'd5);
    tick();
    tick();
    check("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
    check("pre_rst_a", ex_a, 32'h0000_00AA);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_async_a", ex_a, 32'd0);
    check("rst_async_regwrite", {31'b0, ex_regwrite}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_no_stale", {31'b0, ex_valid}, 32'd0);
    tick();
    check("rst_resume_valid", {31'b0, ex_valid}, 32'd1);
    check("rst_r6_cleared", ex_a, 32'd0);
    check("rst_r5_cleared", ex_b, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: inst_in  input  32  fetched instruction; opcode [31:28], rd [27:22], rs1 [21:16], rs2 [15:10], [9:0] ignored.
REQ-004 SHALL have port: pc_in  input  32  PC of inst_in.
REQ-005 SHALL have port: stall  input  1  hold IF/ID and insert bubble into ID/EX.
REQ-006 SHALL have port: flush  input  1  squash IF/ID and ID/EX contents (taken branch/jump).
REQ-007 SHALL have ports: wb_en  input  1, wb_addr  input  6, wb_data  input  32  register-file write-back.
REQ-008 SHALL have ports: ex_valid  output  1, ex_op  output  4, ex_rd  output  6, ex_rs1  output  6, ex_rs2  output  6  registered decode results.
REQ-009 SHALL have ports: ex_a  output  32, ex_b  output  32, ex_pc  output  32  registered operands (R[rs1], R[rs2]) and PC.
REQ-010 SHALL have ports: ex_regwrite, ex_memread, ex_memwrite, ex_jump, ex_brz, ex_brn  output  1 each  registered control.

Function
REQ-011 SHALL contain an IF/ID register (inst, pc, valid) loaded from inst_in/pc_in with valid=1 on each rising edge when stall=0 and flush=0.
REQ-012 SHALL contain an ID/EX register driving all ex_* outputs; inst_in to ex_* latency is 2 cycles with no stall.
REQ-013 SHALL contain a 64 x 32-bit register file, all 64 entries writable, written at rising edge when wb_en=1.
REQ-014 SHALL read R[rs1] and R[rs2] combinationally from the IF/ID instruction; if wb_en=1 and wb_addr equals the read address in the same cycle, wb_data SHALL be forwarded.
REQ-015 SHALL decode opcodes: 0000 NOP, 1111 SVPC, 1110 LD, 0011 ST, 0100 ADD, 0101 INC, 0110 NEG, 0111 SUB, 1000 J, 1001 BRZ, 1010 JM, 1011 BRN.
REQ-016 SHALL set ex_regwrite=1 for SVPC, LD, ADD, INC, NEG, SUB; ex_memread=1 for LD and JM; ex_memwrite=1 for ST; ex_jump=1 for J and JM; ex_brz=1 for BRZ; ex_brn=1 for BRN.
REQ-017 SHALL treat opcodes 0001, 0010, 1100, 1101 and NOP as bubbles: ex_valid=0, all control 0.
REQ-018 SHALL, on stall=1 and flush=0, hold IF/ID unchanged and load ID/EX with a bubble (ex_valid=0, controls 0, fields 0).
REQ-019 SHALL, on flush=1 (priority over stall), load both IF/ID valid and ID/EX with bubbles at that edge.
REQ-020 SHALL, when IF/ID valid=0, load ID/EX with a bubble.
REQ-021 SHALL perform the register-file write independent of stall and flush.
REQ-022 SHALL pass ex_op, ex_rd, ex_rs1, ex_rs2 unchanged from instruction fields for valid instructions.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear IF/ID, ID/EX, and all 64 registers to 0; all ex_* outputs 0.
REQ-024 SHALL, on rst_n deassertion mid-stream, resume capture at the next rising edge with no stale instruction emitted.

Verification
REQ-025 SHALL verify: wb R5=0x0000_0007, R6=0x0000_0003, then inst_in=0x7146_1800 (SUB rd=5 rs1=6 rs2=6) -> 2 cycles later ex_valid=1, ex_op=0111, ex_a=ex_b=0x3, ex_regwrite=1.
REQ-026 SHALL verify: same-cycle wb_en=1 wb_addr=6 wb_data=0xAA while ADD reads rs1=6 -> ex_a=0xAA.
REQ-027 SHALL verify: stall=1 for 2 cycles with LD in IF/ID -> 2 bubbles on ex_*, then LD emitted once with ex_memread=1.
REQ-028 SHALL verify: flush=1 and stall=1 together -> next two cycles ex_valid=0; held instruction discarded.
REQ-029 SHALL verify: rst_n pulsed low mid-stream -> ex_* immediately 0, R[any]=0 on subsequent read.
REQ-030 SHALL verify: opcode 1100 and 0000 -> ex_valid=0; BRN -> ex_brn=1, ex_regwrite=0.
